obstacle_row_gen: RTL and testbench

//  Consumes the free-running 16-bit pseudo-random word from the track LFSR.

---
 rtl/obstacle_row_gen_if.sv | 22 ++
 rtl/obstacle_row_gen.sv | 126 ++++++++++++
 tb/tb_obstacle_row_gen.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/obstacle_row_gen_if.sv
// Row handshake bundle between the obstacle generator and the track scroller.
// The generator drives master; the scroller drives row_ready through slave.
interface obstacle_row_gen_if;
  logic       row_valid;
  logic       row_ready;
  logic [5:0] row_data;
  logic [7:0] row_idx;

  modport master (
    output row_valid,
    output row_data,
    output row_idx,
    input  row_ready
  );

  modport slave (
    input  row_valid,
    input  row_data,
    input  row_idx,
    output row_ready
  );
endinterface

// File: rtl/obstacle_row_gen.sv
// 3-lane obstacle row generator with a small row FIFO and forced gap rows.
// Define OBS_STATS_EN to add the saturating train_cnt statistics output.
module obstacle_row_gen #(
  parameter int DEPTH   = 4,
  parameter int MIN_GAP = 2,
  parameter int DENSITY = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] rand_in,
  input  logic        enable,
  output logic        fifo_full,
`ifdef OBS_STATS_EN
  output logic [15:0] train_cnt,
`endif
  obstacle_row_gen_if.master row_if
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  logic [5:0]    data_q [DEPTH];
  logic [7:0]    idx_q  [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [3:0]    gap_cnt_q;
  logic [3:0]    gap_cnt_d;
  logic [7:0]    wr_seq_q;

  logic       gen;
  logic       pop;
  logic       obst;
  logic [1:0] lane;
  logic [5:0] raw;
  logic [5:0] row_d;
  logic       unused_rand;

  assign unused_rand = ^rand_in[15:12];

  // count is sampled before the pop, so a full FIFO never generates
  assign gen  = enable && (count_q < DEPTH_C);
  assign pop  = row_if.row_valid && row_if.row_ready;
  assign obst = {1'b0, rand_in[11:8]} < 5'(DENSITY);
  assign raw  = rand_in[5:0];
  assign lane = (rand_in[7:6] == 2'd3) ? 2'd0 : rand_in[7:6];

  always_comb begin
    row_d = '0;
    if (gap_cnt_q == '0 && obst) begin
      row_d = raw;
      // an all-train row would block the player: open one lane
      if (raw == 6'h3F) begin
        unique case (1'b1)
          lane == 2'd0: row_d[1:0] = 2'b00;
          lane == 2'd1: row_d[3:2] = 2'b00;
          default:      row_d[5:4] = 2'b00;
        endcase
      end
    end
  end

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (gen) begin
      if (gap_cnt_q != '0)
        gap_cnt_d = gap_cnt_q - 4'd1;
      else if (row_d != '0)
        gap_cnt_d = 4'(MIN_GAP);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        data_q[i] <= '0;
        idx_q[i]  <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      gap_cnt_q <= '0;
      wr_seq_q  <= '0;
    end else begin
      if (gen) begin
        data_q[wr_ptr_q] <= row_d;
        idx_q[wr_ptr_q]  <= wr_seq_q;
        wr_ptr_q         <= wr_ptr_q + 1'b1;
        wr_seq_q         <= wr_seq_q + 8'd1;
      end
      if (pop)
        rd_ptr_q <= rd_ptr_q + 1'b1;
      if (gen && !pop)
        count_q <= count_q + 1'b1;
      else if (!gen && pop)
        count_q <= count_q - 1'b1;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  assign row_if.row_valid = (count_q != '0);
  assign row_if.row_data  = data_q[rd_ptr_q];
  assign row_if.row_idx   = idx_q[rd_ptr_q];
  assign fifo_full        = (count_q == DEPTH_C);

`ifdef OBS_STATS_EN
  logic [1:0]  trains;
  logic [16:0] train_sum;
  logic [15:0] train_cnt_q;

  assign trains = 2'(row_d[1:0] == 2'b11)
                + 2'(row_d[3:2] == 2'b11)
                + 2'(row_d[5:4] == 2'b11);
  assign train_sum = {1'b0, train_cnt_q} + 17'(trains);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      train_cnt_q <= '0;
    else if (gen)
      train_cnt_q <= train_sum[16] ? 16'hFFFF : train_sum[15:0];
  end

  assign train_cnt = train_cnt_q;
`endif

endmodule

// File: tb/tb_obstacle_row_gen.sv
// Scoreboard bench for obstacle_row_gen: directed stimulus queues expected
// rows, a negedge monitor pops and compares on every handshake.
module tb_obstacle_row_gen;

  typedef struct packed {
    logic [5:0] d;
    logic [7:0] i;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] rand_in = '0;
  logic        enable = 1'b0;
  logic        ready = 1'b0;
  logic        fifo_full;
`ifdef OBS_STATS_EN
  logic [15:0] train_cnt;
`endif

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  obstacle_row_gen_if rif ();
  assign rif.row_ready = ready;

  obstacle_row_gen #(
    .DEPTH(4), .MIN_GAP(2), .DENSITY(6)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rand_in(rand_in),
    .enable(enable),
    .fifo_full(fifo_full),
`ifdef OBS_STATS_EN
    .train_cnt(train_cnt),
`endif
    .row_if(rif.master)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a handshake seen at negedge completes on the next posedge
  always @(negedge clk) begin
    if (!rst && rif.row_valid === 1'b1 && ready) begin
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("row_data", 32'(rif.row_data), 32'(e.d));
        chk("row_idx", 32'(rif.row_idx), 32'(e.i));
      end else begin
        chk("extra_row", 32'(rif.row_idx), 32'hFFFF_FFFF);
      end
    end
  end

  task automatic push(logic [5:0] d, logic [7:0] i);
    exp_t e;
    e.d = d;
    e.i = i;
    q.push_back(e);
  endtask

  task automatic drain(int budget);
    ready = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      if (q.size() == 0) break;
    end
    #1 ready = 1'b0;
    if (q.size() != 0) begin
      chk("drain_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    enable = 1'b0;
    ready = 1'b0;
    #1 chk("async_valid", 32'(rif.row_valid), 32'd0);
    q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_valid", 32'(rif.row_valid), 32'd0);
    chk("rst_data", 32'(rif.row_data), 32'd0);
    chk("rst_idx", 32'(rif.row_idx), 32'd0);
    chk("rst_full", 32'(fifo_full), 32'd0);
`ifdef OBS_STATS_EN
    chk("rst_train", 32'(train_cnt), 32'd0);
`endif
  endtask

  initial begin
    // fill to full, then pop while full: no push that cycle
    do_reset();
    rand_in = 16'h0000;
    enable = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("fill_full", 32'(fifo_full), 32'd1);
    chk("fill_valid", 32'(rif.row_valid), 32'd1);
    chk("fill_idx", 32'(rif.row_idx), 32'd0);
    push(6'h00, 8'd0);
    ready = 1'b1;
    @(posedge clk);
    #1 ready = 1'b0;
    chk("pop_full_nopush", 32'(fifo_full), 32'd0);
    chk("pop_head_idx", 32'(rif.row_idx), 32'd1);
    @(posedge clk);
    #1 chk("refill_full", 32'(fifo_full), 32'd1);
    for (int k = 1; k <= 4; k++) push(6'h00, 8'(k));
    drain(50);

    // all-train raw row, lane 0 opened, MIN_GAP=2 empty rows
    do_reset();
    rand_in = 16'h003F;
    enable = 1'b1;
    push(6'h3C, 8'd0);
    push(6'h00, 8'd1);
    push(6'h00, 8'd2);
    push(6'h3C, 8'd3);
    push(6'h00, 8'd4);
    push(6'h00, 8'd5);
    push(6'h3C, 8'd6);
    drain(100);

    // DENSITY boundary: nibble 6 gives empty row, 5 gives obstacle
    do_reset();
    rand_in = 16'h063F;
    enable = 1'b1;
    @(posedge clk);
    #1 rand_in = 16'h053F;
    @(posedge clk);
    #1 enable = 1'b0;
    push(6'h00, 8'd0);
    push(6'h3C, 8'd1);
    drain(50);

    // lane select: 3 maps to lane 0, 1 opens lane 1
    do_reset();
    rand_in = 16'h00FF;
    enable = 1'b1;
    @(posedge clk);
    #1 rand_in = 16'h007F;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    chk("lane_full", 32'(fifo_full), 32'd1);
`ifdef OBS_STATS_EN
    chk("train_cnt", 32'(train_cnt), 32'd4);
`endif
    push(6'h3C, 8'd0);
    push(6'h00, 8'd1);
    push(6'h00, 8'd2);
    push(6'h33, 8'd3);
    drain(50);

    // 300 continuous pops: row_idx wraps 255 -> 0
    do_reset();
    rand_in = 16'h0000;
    enable = 1'b1;
    for (int k = 0; k < 300; k++) push(6'h00, 8'(k));
    drain(1000);

    // async reset with 3 rows buffered
    do_reset();
    rand_in = 16'h0000;
    enable = 1'b1;
    repeat (3) @(posedge clk);
    #1 enable = 1'b0;
    chk("three_valid", 32'(rif.row_valid), 32'd1);
    chk("three_full", 32'(fifo_full), 32'd0);
    do_reset();
    enable = 1'b1;
    @(posedge clk);
    #1 enable = 1'b0;
    push(6'h00, 8'd0);
    drain(50);

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
